// File: rtl/tug_pkg.sv
// Shared constants and types for the tug-of-war scorer.
// Holds the LED mux mode encodings, the rope-position constants,
// the winner encodings and the scorer's state type.
package tug_pkg;

   // Display-mode select values for the LED mux. 2'b11 is reserved and never driven.
   localparam logic [1:0] LEDS_SHOW_SCORE = 2'b00;
   localparam logic [1:0] LEDS_ALL_ON     = 2'b01;
   localparam logic [1:0] LEDS_ALL_OFF    = 2'b10;

   // One-hot rope positions; bit6 is the left player's end.
   localparam logic [6:0] CENTER    = 7'b0001000;
   localparam logic [6:0] LEFT_END  = 7'b1000000;
   localparam logic [6:0] RIGHT_END = 7'b0000001;

   // Winner indication.
   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2
   } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already synchronised, debounced button level.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the remembered level
//   level - button level
//   pulse - high for the single cycle in which level is high and was low
//           on the previous cycle
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev_level;

   // Clearing the remembered level on reset means a button held through
   // reset release is seen as a fresh press on the first free cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_level <= 1'b0;
      end else begin
         prev_level <= level;
      end
   end

   // Combinational so a press acts on the same edge at which it is first sampled.
   assign pulse = level & ~prev_level;

endmodule

// File: rtl/tug_scorer.sv
// Tug-of-war scorer: tracks a one-hot rope position moved by two players'
// buttons, declares a winner when the rope reaches either end, and flashes
// the display while a win is shown.
// Parameters:
//   FLASH_DIV - clock cycles per half-period of the win flash
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   pbl, pbr  - left / right button levels (synchronised, debounced)
//   clear     - new-game request level
//   leds_ctrl - LED mux mode select (registered)
//   score     - one-hot rope position, bit6 = left end (registered)
//   winner    - 2'b10 left, 2'b01 right, 2'b00 none (registered)
module tug_scorer
   import tug_pkg::*;
#(
   parameter int FLASH_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pbl,
   input  logic       pbr,
   input  logic       clear,
   output logic [1:0] leds_ctrl,
   output logic [6:0] score,
   output logic [1:0] winner
);

   // A width of at least one keeps the counter legal for FLASH_DIV = 1.
   localparam int CNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_DIV - 1);

   state_t           state;
   logic [CNT_W-1:0] flash_cnt;
   logic             press_l;
   logic             press_r;
   logic [6:0]       score_left;
   logic [6:0]       score_right;

   edge_detect u_edge_l (
      .clk   (clk),
      .rst   (rst),
      .level (pbl),
      .pulse (press_l)
   );

   edge_detect u_edge_r (
      .clk   (clk),
      .rst   (rst),
      .level (pbr),
      .pulse (press_r)
   );

   // The rope is never at an end while in PLAY (reaching one leaves PLAY on
   // the same edge), so a one-bit shift can neither wrap nor empty the score.
   assign score_left  = {score[5:0], 1'b0};
   assign score_right = {1'b0, score[6:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         leds_ctrl <= LEDS_ALL_ON;
         score     <= CENTER;
         winner    <= WIN_NONE;
         flash_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // The starting press only wakes the game up; it does not move the rope.
               if (!clear && (press_l || press_r)) begin
                  state     <= PLAY;
                  leds_ctrl <= LEDS_SHOW_SCORE;
               end
            end

            PLAY: begin
               if (clear) begin
                  state     <= IDLE;
                  leds_ctrl <= LEDS_ALL_ON;
                  score     <= CENTER;
                  winner    <= WIN_NONE;
               end else if (press_l && !press_r) begin
                  score <= score_left;
                  if (score_left == LEFT_END) begin
                     state     <= WIN;
                     winner    <= WIN_LEFT;
                     flash_cnt <= '0;
                     leds_ctrl <= LEDS_SHOW_SCORE;
                  end
               end else if (press_r && !press_l) begin
                  score <= score_right;
                  if (score_right == RIGHT_END) begin
                     state     <= WIN;
                     winner    <= WIN_RIGHT;
                     flash_cnt <= '0;
                     leds_ctrl <= LEDS_SHOW_SCORE;
                  end
               end
            end

            WIN: begin
               if (clear) begin
                  state     <= IDLE;
                  leds_ctrl <= LEDS_ALL_ON;
                  score     <= CENTER;
                  winner    <= WIN_NONE;
                  flash_cnt <= '0;
               end else if (flash_cnt == FLASH_LAST) begin
                  flash_cnt <= '0;
                  leds_ctrl <= (leds_ctrl == LEDS_SHOW_SCORE) ? LEDS_ALL_OFF : LEDS_SHOW_SCORE;
               end else begin
                  flash_cnt <= flash_cnt + CNT_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               leds_ctrl <= LEDS_ALL_ON;
               score     <= CENTER;
               winner    <= WIN_NONE;
               flash_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/tug_scorer.md
TUG_SCORER -- requirements
Module: tug_scorer

Interface
REQ-001 Parameter FLASH_DIV, default 25_000_000: clock cycles per half-period of the win flash.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pbl  input  1  left-player button level, already synchronised and debounced.
REQ-005 pbr  input  1  right-player button level, already synchronised and debounced.
REQ-006 clear  input  1  new-game request, level, sampled every cycle.
REQ-007 leds_ctrl  output  2  display-mode select for the LED mux; registered.
REQ-008 score  output  7  one-hot rope position, bit6 = left end, bit0 = right end; registered.
REQ-009 winner  output  2  2'b10 left won, 2'b01 right won, 2'b00 no winner; registered.

Function
REQ-010 leds_ctrl encoding SHALL be: 2'b00 SHOW_SCORE, 2'b01 ALL_ON, 2'b10 ALL_OFF, 2'b11 reserved (never driven).
REQ-011 Press detection SHALL use rising edges only: press = level high now and low on the previous cycle; holding a button produces exactly one press.
REQ-012 The FSM SHALL have states IDLE, PLAY and WIN.
REQ-013 IDLE: leds_ctrl=ALL_ON, score=7'b0001000 (CENTER), winner=00.
REQ-014 IDLE->PLAY on the first press of either button; that press SHALL NOT move the rope.
REQ-015 PLAY: leds_ctrl=SHOW_SCORE.
REQ-016 In PLAY, a left-only press SHALL shift score one bit toward bit6; a right-only press SHALL shift it one bit toward bit0.
REQ-017 Simultaneous left and right presses in the same cycle SHALL leave score unchanged.
REQ-018 Each score update SHALL be visible on the outputs after the clock edge at which the button is first sampled high (single-cycle latency from that edge).
REQ-019 PLAY->WIN on the same edge that score becomes 7'b1000000 (winner=10) or 7'b0000001 (winner=01).
REQ-020 Score SHALL never wrap around and never go to zero.
REQ-021 WIN: score and winner frozen; button presses ignored.
REQ-022 In WIN, leds_ctrl SHALL start at SHOW_SCORE and toggle between SHOW_SCORE and ALL_OFF every FLASH_DIV cycles.
REQ-023 The flash counter SHALL be cleared on WIN entry and be $clog2(FLASH_DIV) bits wide.
REQ-024 clear=1 in PLAY or WIN SHALL force IDLE on the next edge, with IDLE output values.
REQ-025 clear SHALL take priority over a same-cycle press.
REQ-026 clear=1 held in IDLE SHALL block the IDLE->PLAY transition.

Reset
REQ-027 rst=1 SHALL force on the next edge: state IDLE, leds_ctrl=ALL_ON, score=CENTER, winner=00, flash counter 0, both previous-level registers 0.
REQ-028 rst SHALL override clear and presses.
REQ-029 Reset mid-PLAY or mid-WIN SHALL discard the position.
REQ-030 A button held through the release of rst SHALL register one press on the first cycle after rst deasserts.

Structure
REQ-031 Package tug_pkg SHALL hold the leds_ctrl encodings, the CENTER, LEFT_END and RIGHT_END constants, and the state type.
REQ-032 Sub-module edge_detect (clk, rst, level -> pulse) SHALL be instantiated once per button.
REQ-033 All outputs SHALL be driven directly from flops.

Verification
REQ-034 Reset then pbl pulse -> state PLAY, score=0001000, leds_ctrl=00.
REQ-035 From CENTER, three separate pbl presses -> score 0010000, 0100000, 1000000; winner=10; leds_ctrl toggles 00/10 every FLASH_DIV cycles (bench FLASH_DIV=4).
REQ-036 pbr held high 20 cycles in PLAY -> exactly one step toward bit0.
REQ-037 pbl and pbr rising in the same cycle -> score unchanged.
REQ-038 In WIN with winner=01: press ignored; clear=1 -> IDLE, score=0001000, leds_ctrl=01, winner=00.
REQ-039 rst asserted in PLAY with score 0000010 and a same-cycle press -> IDLE values on the next edge.
